// File: rtl/mmu_pkg.sv
// Shared constants for the segment MMU: CPU mode encodings and fault cause codes.
package mmu_pkg;
  localparam logic KERNEL_MODE = 1'b0;
  localparam logic USER_MODE   = 1'b1;

  localparam logic [1:0] FLT_NONE = 2'b00;
  localparam logic [1:0] FLT_IM   = 2'b01;
  localparam logic [1:0] FLT_DM   = 2'b10;
  localparam logic [1:0] FLT_SEL  = 2'b11;
endpackage

// File: rtl/mmu_seg_xlate.sv
// Combinational base+logical relocation with limit and overflow check for one address path.
module mmu_seg_xlate #(
  parameter int ADDR_W = 26
) (
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W-1:0] limit,
  input  logic [ADDR_W-1:0] logical,
  output logic [ADDR_W-1:0] phys,
  output logic              viol
);
  logic [ADDR_W:0] sum;

  always_comb begin
    sum  = {1'b0, base} + {1'b0, logical};
    phys = sum[ADDR_W-1:0];
    // The limit is inclusive; wrapping past the top of memory is a violation too.
    viol = (logical > limit) || sum[ADDR_W];
  end
endmodule

// File: rtl/mmu_seg.sv
// Base/limit segment MMU: per-process IM/DM segment table, mode register and sticky fault latch.
module mmu_seg
  import mmu_pkg::*;
#(
  parameter int ADDR_W   = 26,
  parameter int NUM_PROC = 16,
  parameter int SEL_W    = $clog2(NUM_PROC)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_base_im,
  input  logic              we_lim_im,
  input  logic              we_base_dm,
  input  logic              we_lim_dm,
  input  logic              we_sel,
  input  logic [31:0]       sel,
  input  logic [31:0]       wdata,
  input  logic              user_mode,
  input  logic              kernel_mode,
  input  logic              inta,
  input  logic [ADDR_W-1:0] im_addr_in,
  input  logic              dm_req,
  input  logic [ADDR_W-1:0] dm_addr_in,
  input  logic              fault_ack,
  output logic [ADDR_W-1:0] im_addr_out,
  output logic [ADDR_W-1:0] dm_addr_out,
  output logic              is_user,
  output logic              fault,
  output logic [1:0]        fault_code,
  output logic [ADDR_W-1:0] fault_addr
);
  logic [ADDR_W-1:0] base_im_q [NUM_PROC];
  logic [ADDR_W-1:0] base_im_d [NUM_PROC];
  logic [ADDR_W-1:0] lim_im_q  [NUM_PROC];
  logic [ADDR_W-1:0] lim_im_d  [NUM_PROC];
  logic [ADDR_W-1:0] base_dm_q [NUM_PROC];
  logic [ADDR_W-1:0] base_dm_d [NUM_PROC];
  logic [ADDR_W-1:0] lim_dm_q  [NUM_PROC];
  logic [ADDR_W-1:0] lim_dm_d  [NUM_PROC];

  logic [SEL_W-1:0]  sel_q, sel_d;
  logic              sel_bad_q, sel_bad_d;
  logic              mode_q, mode_d;
  logic              fault_q, fault_d;
  logic [1:0]        fault_code_q, fault_code_d;
  logic [ADDR_W-1:0] fault_addr_q, fault_addr_d;
  logic [ADDR_W-1:0] im_out_q, im_out_d;
  logic [ADDR_W-1:0] dm_out_q, dm_out_d;

  logic [SEL_W-1:0]  idx;
  logic [ADDR_W-1:0] im_phys, dm_phys;
  logic              im_xviol, dm_xviol;
  logic              user, im_viol, dm_viol, capture;
  logic              unused_wdata;

  assign unused_wdata = ^wdata[31:ADDR_W];

  // A bad selector still indexes something; park it on slot 0 so the lookup stays in range.
  assign idx = sel_bad_q ? '0 : sel_q;

  mmu_seg_xlate #(.ADDR_W(ADDR_W)) u_xlate_im (
    .base    (base_im_q[idx]),
    .limit   (lim_im_q[idx]),
    .logical (im_addr_in),
    .phys    (im_phys),
    .viol    (im_xviol)
  );

  mmu_seg_xlate #(.ADDR_W(ADDR_W)) u_xlate_dm (
    .base    (base_dm_q[idx]),
    .limit   (lim_dm_q[idx]),
    .logical (dm_addr_in),
    .phys    (dm_phys),
    .viol    (dm_xviol)
  );

  always_comb begin
    base_im_d = base_im_q;
    lim_im_d  = lim_im_q;
    base_dm_d = base_dm_q;
    lim_dm_d  = lim_dm_q;
    if (!sel_bad_q) begin
      if (we_base_im) base_im_d[sel_q] = wdata[ADDR_W-1:0];
      if (we_lim_im)  lim_im_d[sel_q]  = wdata[ADDR_W-1:0];
      if (we_base_dm) base_dm_d[sel_q] = wdata[ADDR_W-1:0];
      if (we_lim_dm)  lim_dm_d[sel_q]  = wdata[ADDR_W-1:0];
    end
  end

  always_comb begin
    sel_d     = sel_q;
    sel_bad_d = sel_bad_q;
    if (we_sel) begin
      sel_d     = sel[SEL_W-1:0];
      sel_bad_d = (sel >= 32'(NUM_PROC));
    end
  end

  always_comb begin
    user    = (mode_q == USER_MODE);
    im_viol = user && (sel_bad_q || im_xviol);
    dm_viol = user && dm_req && (sel_bad_q || dm_xviol);
    // A violation landing together with fault_ack replaces the acknowledged fault.
    capture = (im_viol || dm_viol) && (!fault_q || fault_ack);

    im_out_d = !user ? im_addr_in : (im_viol ? '0 : im_phys);
    dm_out_d = !user ? dm_addr_in : (dm_viol ? '0 : dm_phys);

    mode_d = mode_q;
    if (capture || kernel_mode || inta) mode_d = KERNEL_MODE;
    else if (user_mode)                 mode_d = USER_MODE;

    fault_d      = fault_q;
    fault_code_d = fault_code_q;
    fault_addr_d = fault_addr_q;
    if (capture) begin
      fault_d      = 1'b1;
      fault_code_d = sel_bad_q ? FLT_SEL : (im_viol ? FLT_IM : FLT_DM);
      fault_addr_d = im_viol ? im_addr_in : dm_addr_in;
    end else if (fault_ack) begin
      fault_d      = 1'b0;
      fault_code_d = FLT_NONE;
      fault_addr_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_PROC; i++) begin
        base_im_q[i] <= '0;
        lim_im_q[i]  <= '0;
        base_dm_q[i] <= '0;
        lim_dm_q[i]  <= '0;
      end
      sel_q        <= '0;
      sel_bad_q    <= 1'b0;
      mode_q       <= KERNEL_MODE;
      fault_q      <= 1'b0;
      fault_code_q <= FLT_NONE;
      fault_addr_q <= '0;
      im_out_q     <= '0;
      dm_out_q     <= '0;
    end else begin
      base_im_q    <= base_im_d;
      lim_im_q     <= lim_im_d;
      base_dm_q    <= base_dm_d;
      lim_dm_q     <= lim_dm_d;
      sel_q        <= sel_d;
      sel_bad_q    <= sel_bad_d;
      mode_q       <= mode_d;
      fault_q      <= fault_d;
      fault_code_q <= fault_code_d;
      fault_addr_q <= fault_addr_d;
      im_out_q     <= im_out_d;
      dm_out_q     <= dm_out_d;
    end
  end

  assign im_addr_out = im_out_q;
  assign dm_addr_out = dm_out_q;
  assign is_user     = mode_q;
  assign fault       = fault_q;
  assign fault_code  = fault_code_q;
  assign fault_addr  = fault_addr_q;
endmodule

// File: tb/tb_mmu_seg.sv
// Directed bench for mmu_seg: translation, bounds faults, selector handling, mode priority, reset.
module tb_mmu_seg;
  localparam int ADDR_W = 26;

  logic              clk = 1'b0;
  logic              rst;
  logic              we_base_im, we_lim_im, we_base_dm, we_lim_dm, we_sel;
  logic [31:0]       sel, wdata;
  logic              user_mode, kernel_mode, inta;
  logic [ADDR_W-1:0] im_addr_in, dm_addr_in;
  logic              dm_req, fault_ack;
  logic [ADDR_W-1:0] im_addr_out, dm_addr_out, fault_addr;
  logic              is_user, fault;
  logic [1:0]        fault_code;

  int checks = 0;
  int failures = 0;

  mmu_seg #(.ADDR_W(ADDR_W), .NUM_PROC(16)) dut (
    .clk(clk), .rst(rst),
    .we_base_im(we_base_im), .we_lim_im(we_lim_im),
    .we_base_dm(we_base_dm), .we_lim_dm(we_lim_dm),
    .we_sel(we_sel), .sel(sel), .wdata(wdata),
    .user_mode(user_mode), .kernel_mode(kernel_mode), .inta(inta),
    .im_addr_in(im_addr_in), .dm_req(dm_req), .dm_addr_in(dm_addr_in),
    .fault_ack(fault_ack),
    .im_addr_out(im_addr_out), .dm_addr_out(dm_addr_out),
    .is_user(is_user), .fault(fault), .fault_code(fault_code),
    .fault_addr(fault_addr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clr_we();
    we_base_im = 0; we_lim_im = 0; we_base_dm = 0; we_lim_dm = 0; we_sel = 0;
  endtask

  task automatic go_user();
    user_mode = 1; tick(); user_mode = 0;
  endtask

  task automatic ack();
    fault_ack = 1; tick(); fault_ack = 0;
  endtask

  task automatic set_sel(input logic [31:0] s);
    we_sel = 1; sel = s; tick(); we_sel = 0;
  endtask

  initial begin
    clr_we();
    sel = 0; wdata = 0; user_mode = 0; kernel_mode = 0; inta = 0;
    im_addr_in = 0; dm_addr_in = 0; dm_req = 0; fault_ack = 0;
    rst = 1;
    #12;
    chk("rst_im_out", 32'(im_addr_out), 0);
    chk("rst_dm_out", 32'(dm_addr_out), 0);
    chk("rst_is_user", 32'(is_user), 0);
    chk("rst_fault", 32'(fault), 0);
    chk("rst_code", 32'(fault_code), 0);
    chk("rst_faddr", 32'(fault_addr), 0);
    @(negedge clk); rst = 0;

    // Kernel mode passes addresses straight through
    im_addr_in = 26'h0001234; dm_addr_in = 26'h55; tick();
    chk("kern_im", 32'(im_addr_out), 32'h1234);
    chk("kern_dm", 32'(dm_addr_out), 32'h55);
    chk("kern_user", 32'(is_user), 0);
    chk("kern_fault", 32'(fault), 0);

    // Slot 3: IM base/limit, DM base+limit written together
    set_sel(3);
    we_base_im = 1; wdata = 32'h100000; tick(); clr_we();
    we_lim_im = 1; wdata = 32'h0FFF; tick(); clr_we();
    we_base_dm = 1; we_lim_dm = 1; wdata = 32'h200; tick(); clr_we();
    go_user();
    chk("enter_user", 32'(is_user), 1);

    im_addr_in = 26'h10; dm_req = 1; dm_addr_in = 26'h10; tick();
    chk("user_im", 32'(im_addr_out), 32'h100010);
    chk("user_dm", 32'(dm_addr_out), 32'h210);
    chk("user_is_user", 32'(is_user), 1);
    chk("user_nofault", 32'(fault), 0);

    im_addr_in = 26'hFFF; dm_addr_in = 26'h200; tick();
    chk("lim_eq_im", 32'(im_addr_out), 32'h100FFF);
    chk("lim_eq_dm", 32'(dm_addr_out), 32'h400);
    chk("lim_eq_nofault", 32'(fault), 0);

    // IM bound fault
    dm_req = 0; im_addr_in = 26'h1000; tick();
    chk("imf_out", 32'(im_addr_out), 0);
    chk("imf_fault", 32'(fault), 1);
    chk("imf_code", 32'(fault_code), 1);
    chk("imf_addr", 32'(fault_addr), 32'h1000);
    chk("imf_kernel", 32'(is_user), 0);
    im_addr_in = 0; ack();
    chk("ack_fault", 32'(fault), 0);
    chk("ack_code", 32'(fault_code), 0);
    chk("ack_addr", 32'(fault_addr), 0);

    // Simultaneous IM and DM violation: IM wins
    go_user();
    im_addr_in = 26'h1000; dm_req = 1; dm_addr_in = 26'h300; tick();
    chk("both_code", 32'(fault_code), 1);
    chk("both_addr", 32'(fault_addr), 32'h1000);
    chk("both_im", 32'(im_addr_out), 0);
    chk("both_dm", 32'(dm_addr_out), 0);
    im_addr_in = 0; dm_req = 0; ack(); go_user();

    // Same with dm_req=0: DM not checked
    im_addr_in = 26'h1000; dm_addr_in = 26'h300; tick();
    chk("nodm_code", 32'(fault_code), 1);
    chk("nodm_dm", 32'(dm_addr_out), 32'h500);
    im_addr_in = 0; ack(); go_user();

    // DM-only fault
    im_addr_in = 26'h10; dm_req = 1; dm_addr_in = 26'h300; tick();
    chk("dmf_code", 32'(fault_code), 2);
    chk("dmf_addr", 32'(fault_addr), 32'h300);
    chk("dmf_im", 32'(im_addr_out), 32'h100010);
    chk("dmf_dm", 32'(dm_addr_out), 0);
    dm_req = 0;

    // Fault while fault=1: output zeroed, no re-capture, mode kept
    go_user();
    im_addr_in = 26'h1000; tick();
    chk("sticky_im", 32'(im_addr_out), 0);
    chk("sticky_code", 32'(fault_code), 2);
    chk("sticky_addr", 32'(fault_addr), 32'h300);
    chk("sticky_user", 32'(is_user), 1);
    // New violation together with fault_ack is captured
    im_addr_in = 26'h1001; fault_ack = 1; tick(); fault_ack = 0;
    chk("ackviol_fault", 32'(fault), 1);
    chk("ackviol_code", 32'(fault_code), 1);
    chk("ackviol_addr", 32'(fault_addr), 32'h1001);
    chk("ackviol_kernel", 32'(is_user), 0);
    im_addr_in = 0; ack();

    // Bad selector 20: writes ignored, user access faults with code 11
    set_sel(20);
    we_base_im = 1; we_lim_im = 1; wdata = 32'h1000; tick(); clr_we();
    go_user();
    im_addr_in = 26'h10; tick();
    chk("badsel_code", 32'(fault_code), 3);
    chk("badsel_addr", 32'(fault_addr), 32'h10);
    chk("badsel_im", 32'(im_addr_out), 0);
    im_addr_in = 0; ack();
    set_sel(4); go_user();
    im_addr_in = 26'h10; tick();
    chk("slot4_im", 32'(im_addr_out), 0);
    chk("slot4_code", 32'(fault_code), 1);
    im_addr_in = 0; ack();

    // inta beats user_mode; kernel_mode request drops to kernel
    user_mode = 1; inta = 1; tick(); user_mode = 0; inta = 0;
    chk("inta_prio", 32'(is_user), 0);
    go_user();
    chk("user_again", 32'(is_user), 1);
    kernel_mode = 1; tick(); kernel_mode = 0;
    chk("kmode_req", 32'(is_user), 0);

    // Carry out of the top bit
    set_sel(5);
    we_base_im = 1; wdata = 32'h3FFFFF0; tick(); clr_we();
    we_lim_im = 1; wdata = 32'h3FFFFFF; tick(); clr_we();
    go_user();
    im_addr_in = 26'hF; tick();
    chk("top_im", 32'(im_addr_out), 32'h3FFFFFF);
    chk("top_nofault", 32'(fault), 0);
    im_addr_in = 26'h20; tick();
    chk("carry_im", 32'(im_addr_out), 0);
    chk("carry_code", 32'(fault_code), 1);
    chk("carry_addr", 32'(fault_addr), 32'h20);

    // Async reset mid-operation clears fault and tables
    #2 rst = 1; #1;
    chk("arst_fault", 32'(fault), 0);
    chk("arst_code", 32'(fault_code), 0);
    @(negedge clk); rst = 0;
    set_sel(5); go_user();
    im_addr_in = 0; tick();
    chk("arst_tbl_im", 32'(im_addr_out), 0);
    chk("arst_tbl_nofault", 32'(fault), 0);
    im_addr_in = 26'h1; tick();
    chk("arst_tbl_lim", 32'(fault_code), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mmu_seg.md
Name: mmu_seg

Overview:
- Parametrised base/limit segment MMU; successor to the single-table instruction relocator.
- Translates instruction-fetch and data logical addresses to physical addresses for the process chosen by a segment selector. Bounds-checks every user-mode access and raises a sticky fault to the interrupt controller.
- Sits between the PC/ALU address paths and the instruction/data memories. Runs on the single core clock, with no separate memory clock.

Parameters:
- ADDR_W, 26, physical/logical address width for both IM and DM.
- NUM_PROC, 16, number of process segment slots.
- SEL_W, $clog2(NUM_PROC), selector index width.

Ports:
- clk  in  1  core clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- we_base_im  in  1  write wdata into IM base of current slot
- we_lim_im  in  1  write wdata into IM limit of current slot
- we_base_dm  in  1  write wdata into DM base of current slot
- we_lim_dm  in  1  write wdata into DM limit of current slot
- we_sel  in  1  load selector from sel
- sel  in  32  new selector value
- wdata  in  32  table write data, low ADDR_W bits used
- user_mode  in  1  request switch to user mode
- kernel_mode  in  1  request switch to kernel mode
- inta  in  1  interrupt acknowledge, forces kernel mode
- im_addr_in  in  ADDR_W  logical fetch address
- dm_req  in  1  data access valid this cycle
- dm_addr_in  in  ADDR_W  logical data address
- fault_ack  in  1  clear sticky fault
- im_addr_out  out  ADDR_W  physical fetch address, registered
- dm_addr_out  out  ADDR_W  physical data address, registered
- is_user  out  1  1 = user mode
- fault  out  1  sticky protection fault
- fault_code  out  2  01 IM bound, 10 DM bound, 11 bad selector
- fault_addr  out  ADDR_W  logical address that faulted

Behaviour:
- Reset (async): mode=kernel, selector=0, all base/limit entries=0, every output=0.
- Table writes:
  - All four write enables target entry [selector]. The new value is visible to translations from the next cycle.
  - Multiple enables may be asserted in the same cycle; each updates its own field.
  - If the selector is >= NUM_PROC, writes are ignored.
- Selector: we_sel loads sel[SEL_W-1:0]. A value with any upper bit set, or >= NUM_PROC, is still stored. It then raises a bad-selector fault on the next user-mode access.
- Mode register:
  - kernel_mode or inta has priority over user_mode when both are asserted.
  - A fault capture also forces kernel mode in the same edge.
  - is_user reflects the registered mode.
- Kernel-mode translation: out = in, with no check.
- User-mode translation: phys = base + logical, computed in ADDR_W+1 bits.
- Violation, checked per path:
  - logical > limit, or carry out of bit ADDR_W-1, or bad selector;
  - the DM check applies only when dm_req=1.
- Latency: 1 cycle. Outputs are registered from the current inputs and the current mode/selector/table. A mode change takes effect on the translation issued the cycle after it is registered.
- On violation:
  - the affected output registers 0;
  - if fault=0: fault<=1, fault_code/fault_addr captured, mode<=kernel.
- IM and DM violating in the same cycle: IM wins the capture, and both outputs still register 0.
- Faults while fault=1 are not re-captured; their outputs are still zeroed.
- fault_ack clears fault, fault_code and fault_addr next edge. A new violation in the same cycle as fault_ack has priority and is captured.
- Reset asserted mid-operation clears the fault and the tables immediately.

Decomposition:
- Shared package mmu_pkg: mode constants KERNEL_MODE=0 and USER_MODE=1, fault code constants FLT_NONE/FLT_IM/FLT_DM/FLT_SEL.
- One natural sub-module, mmu_seg_xlate: combinational base+limit adder/comparator. It is instantiated twice, once for the IM path and once for the DM path.
- Table, mode register and fault latch stay in the top level.

Test Plan:
- Reset, then kernel mode, im_addr_in=0x0001234 -> im_addr_out=0x0001234 one cycle later, is_user=0, fault=0.
- Selector 3, base_im=0x100000, lim_im=0x0FFF, user_mode, im_addr_in=0x0010 -> im_addr_out=0x100010, is_user=1.
- Same setup, im_addr_in=0x1000 -> im_addr_out=0, fault=1, code=01, fault_addr=0x1000, is_user=0 next cycle. Then fault_ack -> fault=0.
- Simultaneous IM and DM violation with dm_req=1 -> code=01. Repeat with dm_req=0 -> no DM fault.
- we_sel with sel=20 (NUM_PROC=16), then user access -> code=11. A table write at that selector leaves slot 4 unchanged.
- user_mode and inta in the same cycle -> is_user=0. Base=0x3FFFFF0, addr 0x20 with limit max -> carry fault code=01.
